// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Handshake bundle between two byte requesters, the arbiter and
//               the uart transmit side (valid/ready per channel).
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if;
    // program-loader requester
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    // core requester
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    // uart transmit side
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    // Arbiter side: consumes requester bytes, produces the uart stream.
    modport slave (
        input  req0_valid, req0_data,
        output req0_ready,
        input  req1_valid, req1_data,
        output req1_ready,
        output out_valid, out_data,
        input  out_ready
    );

    // Environment side: drives requesters and the uart ready.
    modport master (
        output req0_valid, req0_data,
        input  req0_ready,
        output req1_valid, req1_data,
        input  req1_ready,
        input  out_valid, out_data,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Two-requester byte arbiter feeding a uart transmitter through
//               a one-entry output register. Ownership is sticky with a burst
//               limit; ties from idle go to the requester that did not own
//               the link last. Per-requester accepted-byte counters.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int BURST_MAX = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    uart_tx_arbiter_if.slave bus,
    output logic [1:0]       grant,
    output logic [31:0]      count0,
    output logic [31:0]      count1
);

    // State encoding doubles as the one-hot grant value.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [7:0] c_burst_max = 8'(BURST_MAX);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_last_owner;
    logic [7:0]  r_burst;
    logic        r_out_valid;
    logic [7:0]  r_out_data;
    logic [31:0] r_count0;
    logic [31:0] r_count1;

    logic        w_can_load;
    logic        w_xfer0;
    logic        w_xfer1;
    logic        w_xfer;
    logic [7:0]  w_burst_inc;
    logic        w_burst_hit;

    // The output register can take a byte when empty or draining this cycle.
    assign w_can_load     = !r_out_valid || bus.out_ready;
    assign bus.req0_ready = (r_state == OWN0) && w_can_load;
    assign bus.req1_ready = (r_state == OWN1) && w_can_load;
    assign w_xfer0        = bus.req0_valid && bus.req0_ready;
    assign w_xfer1        = bus.req1_valid && bus.req1_ready;
    assign w_xfer         = w_xfer0 || w_xfer1;
    assign w_burst_inc    = r_burst + 8'd1;
    // True on the transfer that brings the burst count up to the limit.
    assign w_burst_hit    = w_xfer && (w_burst_inc == c_burst_max);

    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign grant          = r_state;
    assign count0         = r_count0;
    assign count1         = r_count1;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection: sticky ownership, hand over on idle or burst limit.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    w_state_next = r_last_owner ? OWN0 : OWN1;
                end else if (bus.req0_valid) begin
                    w_state_next = OWN0;
                end else if (bus.req1_valid) begin
                    w_state_next = OWN1;
                end
            end
            OWN0: begin
                if (!bus.req0_valid) begin
                    w_state_next = bus.req1_valid ? OWN1 : IDLE;
                end else if (w_burst_hit && bus.req1_valid) begin
                    w_state_next = OWN1;
                end
            end
            OWN1: begin
                if (!bus.req1_valid) begin
                    w_state_next = bus.req0_valid ? OWN0 : IDLE;
                end else if (w_burst_hit && bus.req0_valid) begin
                    w_state_next = OWN0;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Burst counter restarts on every ownership change and at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burst <= 8'd0;
        end else if (w_state_next != r_state) begin
            r_burst <= 8'd0;
        end else if (w_burst_hit) begin
            r_burst <= 8'd0;
        end else if (w_xfer) begin
            r_burst <= w_burst_inc;
        end
    end

    // Remember who owned the link last so idle ties alternate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_owner <= 1'b1;
        end else if ((r_state == OWN0) && (w_state_next != OWN0)) begin
            r_last_owner <= 1'b0;
        end else if ((r_state == OWN1) && (w_state_next != OWN1)) begin
            r_last_owner <= 1'b1;
        end
    end

    // One-entry output register; a load wins over a simultaneous drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
        end else if (w_xfer0) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.req0_data;
        end else if (w_xfer1) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.req1_data;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Accepted-byte counters, free-running with natural wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count0 <= 32'd0;
            r_count1 <= 32'd0;
        end else begin
            if (w_xfer0) begin
                r_count0 <= r_count0 + 32'd1;
            end
            if (w_xfer1) begin
                r_count1 <= r_count1 + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 16, meaning the maximum consecutive bytes one owner may send while the other requester waits; legal range 1..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset that is asynchronous and active-high.
REQ-004 SHALL have port req0_valid, input, 1, program-loader byte valid.
REQ-005 SHALL have port req0_data, input, 8, program-loader byte.
REQ-006 SHALL have port req0_ready, output, 1, program-loader byte accepted this cycle when valid is also high.
REQ-007 SHALL have ports req1_valid, req1_data and req1_ready with the same widths and directions as REQ-004..006, for the core requester.
REQ-008 SHALL have port out_valid, output, 1, byte valid towards the uart transmit side.
REQ-009 SHALL have port out_data, output, 8, byte towards the uart.
REQ-010 SHALL have port out_ready, input, 1, uart accepts the byte.
REQ-011 SHALL have port grant, output, 2, one-hot current owner; 00 means none.
REQ-012 SHALL have ports count0 and count1, output, 32 each, bytes accepted from req0 and req1 respectively.

Function
REQ-013 SHALL implement a state machine with states IDLE, OWN0 and OWN1, and SHALL drive grant as 00, 01 and 10 respectively, registered.
REQ-014 SHALL hold a one-entry output register (out_valid/out_data); a transfer i is (reqi_valid && reqi_ready).
REQ-015 SHALL drive reqi_ready = (state==OWNi) && (!out_valid || out_ready), combinationally; in IDLE both readies SHALL be 0.
REQ-016 SHALL load out_data with reqi_data and set out_valid=1 on transfer i, so latency is 1 cycle from accept to out_valid.
REQ-017 SHALL clear out_valid when out_valid && out_ready and no transfer occurs in that cycle; simultaneous drain and load SHALL keep out_valid=1 with the new byte.
REQ-018 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-019 SHALL go from IDLE, when exactly one reqi_valid is high, to OWNi.
REQ-020 SHALL go from IDLE, when both are valid, to OWN of the requester not recorded as last owner; last owner SHALL be 1 after reset, so req0 wins the first tie.
REQ-021 SHALL stay in IDLE when no requester is valid.
REQ-022 SHALL keep an 8-bit burst counter that clears on every state entry and increments on each transfer in OWNi.
REQ-023 SHALL, in OWNi, rotate when the burst counter reaches BURST_MAX (including the transfer that reaches it) and the other requester is valid: the next state SHALL be OWN(other) directly.
REQ-024 SHALL, when the burst counter reaches BURST_MAX with the other requester idle, clear the counter and stay in OWNi.
REQ-025 SHALL, in OWNi with reqi_valid=0, go to OWN(other) if the other requester is valid, else to IDLE.
REQ-026 SHALL update last owner to i on every exit from OWNi.
REQ-027 SHALL never assert req0_ready and req1_ready in the same cycle.
REQ-028 SHALL increment count0 and count1 by one per transfer and wrap from 0xFFFFFFFF to 0.

Reset
REQ-029 SHALL, while reset=1 and asynchronously, set state=IDLE, grant=00, out_valid=0, out_data=0, burst=0, last owner=1, count0=0 and count1=0.
REQ-030 SHALL discard any byte pending in the output register on reset mid-operation; it SHALL NOT be replayed.
REQ-031 SHALL hold req0_ready and req1_ready at 0 throughout reset.

Verification
REQ-032 The bench SHALL cover single requester: req0 sends 0x41,0x42,0x43 with out_ready=1 -> out_data 0x41,0x42,0x43 each one cycle after accept, grant=01, count0=3.
REQ-033 The bench SHALL cover a tie: both valid from IDLE after reset -> grant=01 first; after req0 drops -> grant=10 with no IDLE cycle.
REQ-034 The bench SHALL cover burst rotation: BURST_MAX=4, both continuously valid -> pattern of 4 req0 bytes, 4 req1 bytes, 4 req0 bytes; readies never both high.
REQ-035 The bench SHALL cover backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data constant, reqi_ready=0; when out_ready returns to 1, a new byte is accepted in the same cycle.
REQ-036 The bench SHALL cover reset mid-burst: assert reset asynchronously with out_valid=1 -> out_valid=0, grant=00 and counts=0 before the next clk edge; the old byte never appears.
REQ-037 The bench SHALL cover wrap-around: count1 forced to 0xFFFFFFFF, then one req1 transfer -> count1=0.
